// File: rtl/uart_bus_initiator.sv
// uart_bus_initiator: host-side initiator for the UART master/slave bridge.
//   Bus side : i_req/i_we/i_addr/i_wdata in; o_busy, o_done, o_rdata, o_timeout out.
//   Data side: i_tx_data/i_tx_valid/o_tx_ready (7-bit stream out),
//              o_rx_data/o_rx_valid/i_rx_ready/o_rx_overflow (7-bit stream in).
//   Serial   : i_uart_rx, o_uart_tx.
// Command bytes carry bit7=1, data-stream bytes bit7=0. Contains its own 8N1
// transmitter/receiver and 2-entry FIFOs.

module uart_tx #(parameter int TICK = 217) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int CW = $clog2(TICK + 1);
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bits;
  logic [8:0]    r_sh;
  logic          r_busy, r_tx;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0; r_bits <= '0; r_sh <= '1; r_busy <= 1'b0; r_tx <= 1'b1;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy <= 1'b1; r_tx <= 1'b0; r_sh <= {1'b1, i_data};
        r_bits <= 4'd9; r_cnt <= CW'(TICK - 1);
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (r_bits == 4'd0) begin
      r_busy <= 1'b0;                       // stop bit has run its full period
    end else begin
      r_tx <= r_sh[0]; r_sh <= {1'b1, r_sh[8:1]};
      r_bits <= r_bits - 4'd1; r_cnt <= CW'(TICK - 1);
    end
  end

  assign o_ready = !r_busy;
  assign o_tx    = r_tx;
endmodule

module uart_rx #(parameter int TICK = 217) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);
  localparam int CW = $clog2(TICK + 1);
  logic          r_s1, r_s2, r_busy, r_vld;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bits;
  logic [7:0]    r_sh;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= 1'b1; r_s2 <= 1'b1; r_busy <= 1'b0; r_vld <= 1'b0;
      r_cnt <= '0; r_bits <= '0; r_sh <= '0;
    end else begin
      r_s1  <= i_rx;
      r_s2  <= r_s1;
      r_vld <= 1'b0;
      if (!r_busy) begin
        // Half a bit minus the synchroniser lag lands samples mid-bit.
        if (!r_s2) begin r_busy <= 1'b1; r_cnt <= CW'(TICK / 2 - 1); r_bits <= 4'd0; end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= CW'(TICK - 1);
        if (r_bits == 4'd0) begin
          if (r_s2) r_busy <= 1'b0;           // glitch, not a start bit
          else      r_bits <= 4'd1;
        end else if (r_bits != 4'd9) begin
          r_sh <= {r_s2, r_sh[7:1]}; r_bits <= r_bits + 4'd1;
        end else begin
          r_busy <= 1'b0; r_vld <= r_s2;      // framing error drops the byte
        end
      end
    end
  end

  assign o_data  = r_sh;
  assign o_valid = r_vld;
endmodule

module uart_bus_fifo2 #(parameter int W = 8) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;

  // Callers gate push/pop; push while full is legal only with a same-cycle pop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem[0] <= '0; r_mem[1] <= '0; r_wp <= 1'b0; r_rp <= 1'b0; r_cnt <= 2'd0;
    end else begin
      if (i_push) begin r_mem[r_wp] <= i_din; r_wp <= ~r_wp; end
      if (i_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
endmodule

module uart_bus_initiator #(
  parameter int BAUDRATE = 115200,
  parameter int SYS_FREQ = 25000000,
  parameter int TIMEOUT  = 250000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_rdata,
  output logic        o_timeout,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic        o_rx_overflow,
  input  logic        i_uart_rx,
  output logic        o_uart_tx
);
  localparam int TICK = SYS_FREQ / BAUDRATE;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_SEND = 3'd1, S_WAIT = 3'd2,
                         S_DONE = 3'd3, S_TOUT = 3'd4;

  logic [2:0]    r_state;
  logic          r_we, r_hi_vld, r_up, r_ovf;
  logic [15:0]   r_addr;
  logic [7:0]    r_wdata, r_rdata;
  logic [1:0]    r_bcnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_hi;

  logic       w_tx_rdy, w_txq_empty, w_txq_full, w_rx_vld, w_rxq_empty, w_rxq_full;
  logic [6:0] w_txq_dout, w_rxq_dout;
  logic [7:0] w_rx_byte, w_cmd_byte, w_tx_byte;
  logic       w_send_data, w_send_cmd, w_last, w_resp, w_ack, w_lo, w_rxq_push, w_rxq_pop;
  logic       w_unused;

  assign w_unused = i_tx_data[7];   // stream is 7 bits wide; bit7 is the framing flag

  always_comb begin
    w_cmd_byte = 8'h00;
    case (r_bcnt)
      2'd0:    w_cmd_byte = {1'b1, r_we, r_addr[15:10]};
      2'd1:    w_cmd_byte = {1'b1, r_addr[9:3]};
      2'd2:    w_cmd_byte = {1'b1, r_addr[2:0], r_we ? r_wdata[7:4] : 4'h0};
      default: w_cmd_byte = {4'b1000, r_wdata[3:0]};
    endcase
  end

  // Pending stream data always wins the transmitter over the command frame.
  assign w_send_data = w_tx_rdy && !w_txq_empty;
  assign w_send_cmd  = w_tx_rdy && w_txq_empty && (r_state == S_SEND);
  assign w_tx_byte   = w_send_data ? {1'b0, w_txq_dout} : w_cmd_byte;
  assign w_last      = (r_bcnt == (r_we ? 2'd3 : 2'd2));

  assign w_resp = w_rx_vld && w_rx_byte[7] && (r_state == S_WAIT);
  assign w_ack  = w_resp && r_we && (w_rx_byte[6:0] == 7'h40);
  assign w_lo   = w_resp && !r_we && r_hi_vld && (w_rx_byte[6:4] == 3'b011);

  assign w_rxq_pop  = !w_rxq_empty && i_rx_ready;
  assign w_rxq_push = w_rx_vld && !w_rx_byte[7] && (!w_rxq_full || w_rxq_pop);

  uart_tx #(.TICK(TICK)) u_tx (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(w_send_data || w_send_cmd),
    .i_data(w_tx_byte), .o_ready(w_tx_rdy), .o_tx(o_uart_tx));

  uart_rx #(.TICK(TICK)) u_rx (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_uart_rx),
    .o_data(w_rx_byte), .o_valid(w_rx_vld));

  uart_bus_fifo2 #(.W(7)) u_txq (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(i_tx_valid && o_tx_ready),
    .i_pop(w_send_data), .i_din(i_tx_data[6:0]), .o_dout(w_txq_dout),
    .o_empty(w_txq_empty), .o_full(w_txq_full));

  uart_bus_fifo2 #(.W(7)) u_rxq (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_rxq_push), .i_pop(w_rxq_pop),
    .i_din(w_rx_byte[6:0]), .o_dout(w_rxq_dout),
    .o_empty(w_rxq_empty), .o_full(w_rxq_full));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE; r_we <= 1'b0; r_addr <= '0; r_wdata <= '0; r_bcnt <= '0;
      r_tcnt <= '0; r_hi <= '0; r_hi_vld <= 1'b0; r_rdata <= '0; r_up <= 1'b0; r_ovf <= 1'b0;
    end else begin
      r_up <= 1'b1;   // keeps o_tx_ready low while in reset
      if (w_rx_vld && !w_rx_byte[7] && w_rxq_full && !w_rxq_pop) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: if (i_req) begin
          r_we <= i_we; r_addr <= i_addr; r_wdata <= i_wdata;
          r_bcnt <= 2'd0; r_state <= S_SEND;
        end
        S_SEND: if (w_send_cmd) begin
          r_bcnt <= r_bcnt + 2'd1;
          if (w_last) begin r_state <= S_WAIT; r_tcnt <= TW'(TIMEOUT - 1); r_hi_vld <= 1'b0; end
        end
        S_WAIT: begin
          if (w_resp && !r_we && (w_rx_byte[6:4] == 3'b010)) begin
            r_hi <= w_rx_byte[3:0]; r_hi_vld <= 1'b1;
          end
          if (w_ack || w_lo) begin
            r_state <= S_DONE;
            if (w_lo) r_rdata <= {r_hi, w_rx_byte[3:0]};
          end else if (r_tcnt == '0) begin
            r_state <= S_TOUT;
          end else begin
            r_tcnt <= r_tcnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;   // DONE / TOUT last exactly one cycle
      endcase
    end
  end

  assign o_busy        = (r_state == S_SEND) || (r_state == S_WAIT);
  assign o_done        = (r_state == S_DONE);
  assign o_timeout     = (r_state == S_TOUT);
  assign o_rdata       = r_rdata;
  assign o_tx_ready    = r_up && !w_txq_full;
  assign o_rx_valid    = !w_rxq_empty;
  assign o_rx_data     = {1'b0, w_rxq_dout};
  assign o_rx_overflow = r_ovf;
endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed bench for uart_bus_initiator: line bytes, response completions and
// received stream bytes are checked against expectations queued at stimulus time.
module tb_uart_bus_initiator;
  localparam int TICK = 4;
  localparam int TOUT = 200;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0, tx_data = '0;
  logic        tx_valid = 1'b0, rx_ready = 1'b0, rx_line = 1'b1;
  logic        busy, done, tout, tx_ready, rx_valid, rx_ovf, uart_tx;
  logic [7:0]  rdata, rx_data;

  uart_bus_initiator #(.BAUDRATE(100), .SYS_FREQ(400), .TIMEOUT(TOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_timeout(tout),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_rx_overflow(rx_ovf), .i_uart_rx(rx_line), .o_uart_tx(uart_tx));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_tout = 0, tout_cyc = 0, last_start = 0;
  logic [7:0] txq[$];    // expected bytes on o_uart_tx
  logic [8:0] doneq[$];  // expected completions: bit8 = read, [7:0] = rdata
  logic [7:0] rxq[$];    // expected stream bytes at o_rx_data

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line monitor: decode each transmitted byte mid-bit; frames cut by reset are dropped.
  initial begin
    logic [7:0] b;
    bit abort;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && !rst) begin
        last_start = cyc;
        abort = 0;
        repeat (TICK / 2) begin @(negedge clk); if (rst) abort = 1; end
        for (int i = 0; i < 8; i++) begin
          repeat (TICK) begin @(negedge clk); if (rst) abort = 1; end
          b[i] = uart_tx;
        end
        repeat (TICK) begin @(negedge clk); if (rst) abort = 1; end
        if (!abort) begin
          chk("tx_stop_bit", uart_tx, 1);
          chk("tx_byte_expected", txq.size() != 0, 1);
          if (txq.size() != 0) chk("tx_byte", b, txq.pop_front());
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        chk("done_busy_low", busy, 0);
        chk("done_expected", doneq.size() != 0, 1);
        if (doneq.size() != 0) begin
          e = doneq.pop_front();
          if (e[8]) chk("rdata", rdata, e[7:0]);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
      end else if (tout === 1'b1) begin
        n_tout++;
        tout_cyc = cyc;
        chk("tout_busy_low", busy, 0);
        @(negedge clk);
        chk("tout_one_cycle", tout, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_line = 1'b0;
    repeat (TICK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (TICK) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (TICK) @(negedge clk);
  endtask

  task automatic request(input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_txq(input string tag);
    for (int i = 0; i < 800 && txq.size() != 0; i++) @(negedge clk);
    chk(tag, txq.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int n0);
    for (int i = 0; i < 100 && n_done == n0; i++) @(negedge clk);
    chk(tag, n_done, n0 + 1);
  endtask

  initial begin
    int n0, t0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_timeout", tout, 0);      chk("rst_rdata", rdata, 0);
    chk("rst_tx_ready", tx_ready, 0); chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);   chk("rst_overflow", rx_ovf, 0);
    chk("rst_line_idle", uart_tx, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("tx_ready_after_rst", tx_ready, 1);

    // Write 0x1234 <= 0xA5 with a stream byte 0xFF offered during B0
    txq.push_back(8'hC4); txq.push_back(8'h7F); txq.push_back(8'hC6);
    txq.push_back(8'hCA); txq.push_back(8'h85);
    doneq.push_back(9'h000);
    request(1'b1, 16'h1234, 8'hA5);
    chk("busy_after_req", busy, 1);
    repeat (6) @(negedge clk);
    chk("stream_ready", tx_ready, 1);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_txq("wr_frame_sent");
    chk("wr_wait_busy", busy, 1);
    n0 = n_done;
    send_byte(8'hC0);
    wait_done("wr_done", n0);

    // Read 0xFFFF -> 0x73
    txq.push_back(8'hBF); txq.push_back(8'hFF); txq.push_back(8'hF0);
    doneq.push_back(9'h173);
    request(1'b0, 16'hFFFF, 8'h00);
    wait_txq("rd_frame_sent");
    n0 = n_done;
    send_byte(8'hA7);
    chk("hi_alone_no_done", n_done, n0);
    chk("hi_alone_busy", busy, 1);
    send_byte(8'hB3);
    wait_done("rd_done", n0);

    // Read 0x0001: lo nibble without preceding hi is ignored -> 0xC9
    txq.push_back(8'h80); txq.push_back(8'h80); txq.push_back(8'h90);
    doneq.push_back(9'h1C9);
    request(1'b0, 16'h0001, 8'h00);
    wait_txq("rd2_frame_sent");
    n0 = n_done;
    send_byte(8'hB5);
    chk("orphan_lo_no_done", n_done, n0);
    send_byte(8'hAC);
    send_byte(8'hB9);
    wait_done("rd2_done", n0);

    // Read 0x0000 with no response -> timeout; request while busy ignored
    txq.push_back(8'h80); txq.push_back(8'h80); txq.push_back(8'h80);
    t0 = n_tout;
    request(1'b0, 16'h0000, 8'h00);
    wait_txq("to_frame_sent");
    request(1'b1, 16'h5555, 8'h55);
    for (int i = 0; i < 400 && n_tout == t0; i++) @(negedge clk);
    chk("tout_pulse", n_tout, t0 + 1);
    chk("tout_delay", tout_cyc - last_start, TOUT);
    chk("tout_rdata_kept", rdata, 8'hC9);
    repeat (10) @(negedge clk);
    chk("busy_req_not_queued", busy, 0);

    // Stream receive: three bytes, consumer stalled -> two held, overflow
    rx_ready = 1'b0;
    chk("ovf_before", rx_ovf, 0);
    n0 = n_done;
    send_byte(8'hC0);   // response code while idle is discarded
    rxq.push_back(8'h11); rxq.push_back(8'h22);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (4) @(negedge clk);
    chk("idle_resp_ignored", n_done, n0);
    chk("ovf_after", rx_ovf, 1);
    for (int k = 0; k < 2; k++) begin
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, rxq.pop_front());
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk("rx_drained", rx_valid, 0);

    // Reset in the middle of B1
    txq.push_back(8'hEA);
    request(1'b1, 16'hABCD, 8'h5A);
    wait_txq("pre_reset_b0");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_line_high", uart_tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ovf_clear", rx_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Next request after reset frames correctly: read 0x1234 -> 0xE1
    txq.push_back(8'h84); txq.push_back(8'hC6); txq.push_back(8'hC0);
    doneq.push_back(9'h1E1);
    request(1'b0, 16'h1234, 8'h00);
    wait_txq("post_reset_frame");
    n0 = n_done;
    send_byte(8'hAE);
    send_byte(8'hB1);
    wait_done("post_reset_done", n0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
